// File: rtl/rle_encoder_if.sv
// Byte-in / (symbol, run)-out handshake bundle for the run-length encoder.
// slave is the encoder's view; master is the producer/consumer side.
interface rle_encoder_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_last;
    logic       in_ready;
    logic [7:0] out_symbol;
    logic [7:0] out_run;
    logic       out_valid;
    logic       out_ready;
    logic       split;

    modport slave (
        input  data_in,
        input  data_valid,
        input  data_last,
        input  out_ready,
        output in_ready,
        output out_symbol,
        output out_run,
        output out_valid,
        output split
    );

    modport master (
        output data_in,
        output data_valid,
        output data_last,
        output out_ready,
        input  in_ready,
        input  out_symbol,
        input  out_run,
        input  out_valid,
        input  split
    );
endinterface

// File: rtl/rle_encoder.sv
// Byte-stream run-length encoder: one byte per cycle in, (symbol, run) pairs out.
// Runs saturate at 255 and are split; the last byte of a stream costs one FLUSH cycle.
module rle_encoder (
    input  logic         clk_i,
    input  logic         rst_ni,
    rle_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [7:0] RUN_MAX = 8'hFF;

    state_e     state_q, state_d;
    logic [7:0] cur_sym_q, cur_sym_d;
    logic [7:0] cur_cnt_q, cur_cnt_d;
    logic [7:0] out_sym_q, out_sym_d;
    logic [7:0] out_run_q, out_run_d;
    logic       out_valid_q, out_valid_d;
    logic       split_q, split_d;

    logic slot_free;
    logic in_ready;
    logic accept;
    logic load;
    logic same_sym;
    logic cnt_full;

    // The output slot can take a new pair if empty or being drained this cycle.
    assign slot_free = !out_valid_q || bus.out_ready;
    assign in_ready  = rst_ni && slot_free && (state_q != ST_FLUSH);
    assign accept    = bus.data_valid && in_ready;
    assign same_sym  = (bus.data_in == cur_sym_q);
    assign cnt_full  = (cur_cnt_q == RUN_MAX);

    always_comb begin
        state_d   = state_q;
        cur_sym_d = cur_sym_q;
        cur_cnt_d = cur_cnt_q;
        load      = 1'b0;
        split_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cur_sym_d = bus.data_in;
                    cur_cnt_d = 8'd1;
                    state_d   = bus.data_last ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (same_sym && !cnt_full) begin
                        cur_cnt_d = cur_cnt_q + 8'd1;
                    end else begin
                        load      = 1'b1;
                        split_d   = same_sym && cnt_full;
                        cur_sym_d = bus.data_in;
                        cur_cnt_d = 8'd1;
                    end
                    state_d = bus.data_last ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (slot_free) begin
                    load      = 1'b1;
                    cur_cnt_d = 8'd0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fresh pair wins over a concurrent drain, so out_valid stays high.
    always_comb begin
        out_sym_d   = out_sym_q;
        out_run_d   = out_run_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_sym_d   = cur_sym_q;
            out_run_d   = cur_cnt_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cur_sym_q   <= 8'h00;
            cur_cnt_q   <= 8'h00;
            out_sym_q   <= 8'h00;
            out_run_q   <= 8'h00;
            out_valid_q <= 1'b0;
            split_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_sym_q   <= cur_sym_d;
            cur_cnt_q   <= cur_cnt_d;
            out_sym_q   <= out_sym_d;
            out_run_q   <= out_run_d;
            out_valid_q <= out_valid_d;
            split_q     <= split_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_symbol = out_sym_q;
    assign bus.out_run    = out_run_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.split      = split_q;

    a_run_nonzero: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid_q |-> (out_run_q != 8'd0));

    a_hold_when_stalled: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_sym_q) && $stable(out_run_q)));

    a_split_with_full_run: assert property (@(posedge clk_i) disable iff (!rst_ni)
        split_q |-> (out_valid_q && (out_run_q == RUN_MAX)));
endmodule

// File: tb/tb_rle_encoder.sv
// Directed table plus hand-written sequences and randomised streams for rle_encoder.
module tb_rle_encoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rle_encoder_if bus();

    rle_encoder dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct packed {
        logic [7:0] sym;
        logic [7:0] run;
    } pair_t;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       l;
        logic       ordy;
        logic       exp_ir;
        logic       exp_ov;
        logic [7:0] exp_sym;
        logic [7:0] exp_run;
    } vec_t;

    int checks = 0;
    int errors = 0;

    pair_t      got_q[$];
    pair_t      exp_q[$];
    logic [7:0] stream_q[$];
    int         acc_bytes = 0;
    int         split_cycles = 0;
    int         zero_runs = 0;
    bit         drv_done;
    vec_t       tbl[16];

    // Transfers happen at the next rising edge; inputs are stable from posedge+1.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_symbol, bus.out_run});
            if (bus.data_valid && bus.in_ready) acc_bytes++;
            if (bus.split) split_cycles++;
            if (bus.out_valid && bus.out_run == 8'd0) zero_runs++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic v, input logic l, input logic o,
                                input logic ir, input logic ov, input logic [7:0] s, input logic [7:0] r);
        vec_t t;
        t.d = d; t.v = v; t.l = l; t.ordy = o;
        t.exp_ir = ir; t.exp_ov = ov; t.exp_sym = s; t.exp_run = r;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int  n = 0;
        bit  done = 1'b0;
        bus.data_in    = b;
        bus.data_valid = 1'b1;
        bus.data_last  = last;
        while (!done) begin
            @(negedge clk);
            done = bus.in_ready;
            tick();
            n++;
            if (!done && n > 300) begin
                checks++;
                errors++;
                $display("FAIL send_byte timeout: byte 0x%0h not accepted after %0d cycles required accept", b, n);
                done = 1'b1;
            end
        end
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
    endtask

    task automatic send_run(input logic [7:0] b, input int n, input bit last_at_end);
        for (int i = 0; i < n; i++) send_byte(b, last_at_end && (i == n - 1));
    endtask

    task automatic wait_pairs(input string name, input int target);
        int n = 0;
        while (got_q.size() < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (got_q.size() < target) begin
            checks++;
            errors++;
            $display("FAIL %s drain timeout: got %0d pairs required %0d", name, got_q.size(), target);
        end
        tick();
    endtask

    task automatic cmp_pairs(input string name, input int base);
        chk({name, " pair count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) begin
                $display("%s pair %0d: sym 0x%02h run %0d (model sym 0x%02h run %0d)", name, i,
                         got_q[base+i].sym, got_q[base+i].run, exp_q[i].sym, exp_q[i].run);
                chk({name, " sym"}, 32'(got_q[base+i].sym), 32'(exp_q[i].sym));
                chk({name, " run"}, 32'(got_q[base+i].run), 32'(exp_q[i].run));
            end
        end
    endtask

    task automatic model_stream();
        logic [7:0] sym = 8'h00;
        int cnt = 0;
        foreach (stream_q[i]) begin
            if (cnt == 0) begin
                sym = stream_q[i];
                cnt = 1;
            end else if (stream_q[i] == sym && cnt < 255) begin
                cnt++;
            end else begin
                exp_q.push_back({sym, 8'(cnt)});
                sym = stream_q[i];
                cnt = 1;
            end
        end
        if (cnt > 0) exp_q.push_back({sym, 8'(cnt)});
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, " in_ready"},   32'(bus.in_ready),   32'd0);
        chk({name, " out_valid"},  32'(bus.out_valid),  32'd0);
        chk({name, " out_symbol"}, 32'(bus.out_symbol), 32'h00);
        chk({name, " out_run"},    32'(bus.out_run),    32'h00);
        chk({name, " split"},      32'(bus.split),      32'd0);
    endtask

    initial begin
        int base;
        int acc0;
        int spl0;
        int sum;

        bus.data_in    = 8'h00;
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        bus.out_ready  = 1'b1;

        //               d     v  l  or   ir ov sym    run
        tbl[0]  = mk(8'h41, 1, 0, 1,  1, 0, 8'h00, 8'd0);
        tbl[1]  = mk(8'h41, 1, 0, 1,  1, 0, 8'h00, 8'd0);
        tbl[2]  = mk(8'h41, 1, 0, 1,  1, 0, 8'h00, 8'd0);
        tbl[3]  = mk(8'h42, 1, 1, 1,  1, 0, 8'h00, 8'd0);
        tbl[4]  = mk(8'h00, 0, 0, 1,  0, 1, 8'h41, 8'd3);
        tbl[5]  = mk(8'h00, 0, 0, 1,  1, 1, 8'h42, 8'd1);
        tbl[6]  = mk(8'h07, 1, 1, 1,  1, 0, 8'h00, 8'd0);
        tbl[7]  = mk(8'h00, 0, 0, 1,  0, 0, 8'h00, 8'd0);
        tbl[8]  = mk(8'h00, 0, 0, 1,  1, 1, 8'h07, 8'd1);
        tbl[9]  = mk(8'h55, 1, 1, 0,  1, 0, 8'h00, 8'd0);
        tbl[10] = mk(8'h00, 0, 0, 0,  0, 0, 8'h00, 8'd0);
        tbl[11] = mk(8'h00, 0, 0, 0,  0, 1, 8'h55, 8'd1);
        tbl[12] = mk(8'h66, 1, 1, 1,  1, 1, 8'h55, 8'd1);
        tbl[13] = mk(8'h00, 0, 0, 1,  0, 0, 8'h00, 8'd0);
        tbl[14] = mk(8'hEE, 0, 1, 1,  1, 1, 8'h66, 8'd1);
        tbl[15] = mk(8'h00, 0, 0, 1,  1, 0, 8'h00, 8'd0);

        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            bus.data_in    = tbl[i].d;
            bus.data_valid = tbl[i].v;
            bus.data_last  = tbl[i].l;
            bus.out_ready  = tbl[i].ordy;
            @(negedge clk);
            $display("vec %0d: in_ready %0d out_valid %0d sym 0x%02h run %0d", i,
                     bus.in_ready, bus.out_valid, bus.out_symbol, bus.out_run);
            chk($sformatf("vec%0d in_ready", i), 32'(bus.in_ready), 32'(tbl[i].exp_ir));
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_ov));
            chk($sformatf("vec%0d split", i), 32'(bus.split), 32'd0);
            if (tbl[i].exp_ov) begin
                chk($sformatf("vec%0d out_symbol", i), 32'(bus.out_symbol), 32'(tbl[i].exp_sym));
                chk($sformatf("vec%0d out_run", i), 32'(bus.out_run), 32'(tbl[i].exp_run));
            end
            tick();
        end
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        bus.out_ready  = 1'b1;

        // 257 identical bytes: saturate, split, then a run of 2.
        base = got_q.size();
        spl0 = split_cycles;
        send_run(8'hAA, 257, 1'b1);
        wait_pairs("run256", base + 2);
        exp_q.delete();
        exp_q.push_back({8'hAA, 8'd255});
        exp_q.push_back({8'hAA, 8'd2});
        cmp_pairs("run256", base);
        chk("run256 split cycles", 32'(split_cycles - spl0), 32'd1);

        // Alternating bytes with the consumer stalled after the first pair.
        base = got_q.size();
        bus.out_ready = 1'b0;
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_byte((i % 2 == 0) ? 8'h00 : 8'hFF, i == 7);
                drv_done = 1'b1;
            end
            begin
                int n = 0;
                while (!bus.out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall in_ready", 32'(bus.in_ready), 32'd0);
                    chk("stall out_valid", 32'(bus.out_valid), 32'd1);
                    chk("stall out_symbol", 32'(bus.out_symbol), 32'h00);
                    chk("stall out_run", 32'(bus.out_run), 32'd1);
                end
                tick();
                bus.out_ready = 1'b1;
            end
        join
        wait_pairs("alt", base + 8);
        repeat (5) tick();
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({((i % 2 == 0) ? 8'h00 : 8'hFF), 8'd1});
        cmp_pairs("alt", base);

        // Reset in the middle of a run of five.
        send_run(8'h33, 5, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset midrun");
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        base = got_q.size();
        repeat (10) tick();
        chk("midrun no emission", 32'(got_q.size() - base), 32'd0);
        send_byte(8'h10, 1'b1);
        wait_pairs("midrun new", base + 1);
        repeat (4) tick();
        exp_q.delete();
        exp_q.push_back({8'h10, 8'd1});
        cmp_pairs("midrun new", base);

        // Reset while a pair is waiting on a stalled consumer.
        bus.out_ready = 1'b0;
        send_run(8'h33, 3, 1'b0);
        send_byte(8'h44, 1'b0);
        @(negedge clk);
        chk("pending out_valid", 32'(bus.out_valid), 32'd1);
        chk("pending out_run", 32'(bus.out_run), 32'd3);
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset pending");
        tick();
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        base = got_q.size();
        repeat (10) tick();
        chk("pending no emission", 32'(got_q.size() - base), 32'd0);
        send_byte(8'h10, 1'b1);
        wait_pairs("pending new", base + 1);
        repeat (4) tick();
        cmp_pairs("pending new", base);

        // Random streams with random valid/ready against the reference model.
        for (int st = 0; st < 3; st++) begin
            int nruns;
            stream_q.delete();
            exp_q.delete();
            nruns = $urandom_range(2, 4);
            for (int r = 0; r < nruns; r++) begin
                int len;
                logic [7:0] s;
                len = (st == 0 && r == 0) ? 600 : $urandom_range(1, 600);
                s = 8'($urandom_range(0, 255));
                for (int k = 0; k < len; k++) stream_q.push_back(s);
            end
            model_stream();
            base = got_q.size();
            acc0 = acc_bytes;
            drv_done = 1'b0;
            fork
                begin
                    foreach (stream_q[i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            bus.data_valid = 1'b0;
                            bus.data_in    = 8'($urandom_range(0, 255));
                            bus.data_last  = 1'($urandom_range(0, 1));
                            tick();
                        end
                        send_byte(stream_q[i], i == stream_q.size() - 1);
                    end
                    drv_done = 1'b1;
                end
                begin
                    while (!drv_done) begin
                        bus.out_ready = ($urandom_range(0, 3) != 0);
                        tick();
                    end
                    bus.out_ready = 1'b1;
                end
            join
            wait_pairs($sformatf("rand%0d", st), base + exp_q.size());
            repeat (4) tick();
            cmp_pairs($sformatf("rand%0d", st), base);
            sum = 0;
            for (int i = base; i < got_q.size(); i++) sum += int'(got_q[i].run);
            chk($sformatf("rand%0d run sum", st), 32'(sum), 32'(stream_q.size()));
            chk($sformatf("rand%0d bytes accepted", st), 32'(acc_bytes - acc0), 32'(stream_q.size()));
        end

        chk("zero run emitted", 32'(zero_runs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rle_encoder.md
# rle_encoder

Byte-stream run-length encoder for the RLE datapath. Accepts one symbol byte per cycle over a valid/ready handshake, tracks the current run with an 8-bit saturating run counter, and emits (symbol, run length) pairs over a second valid/ready handshake. It consumes raw input bytes and feeds the downstream RLE packer/serializer.

## Interface
- No parameters; symbol width 8, run width 8, maximum run 255.
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; 0 forces reset state immediately, release is synchronous to clock.
- data_in  input  8  input symbol byte.
- data_valid  input  1  data_in valid this cycle.
- data_last  input  1  qualifies data_in as final byte of the stream; meaningful only with data_valid.
- in_ready  output  1  encoder can accept a byte this cycle.
- out_symbol  output  8  symbol of emitted run.
- out_run  output  8  run length of emitted run, 1..255; 0 never emitted.
- out_valid  output  1  out_symbol/out_run valid.
- out_ready  input  1  downstream accepts the pair this cycle.
- split  output  1  one-cycle pulse: a run was cut at 255 and continues as a new run.

## Operation
- Accept = data_valid & in_ready. Output transfer = out_valid & out_ready.
- Held state: cur_sym[7:0], cur_cnt[7:0], output register (out_symbol, out_run, out_valid), FSM state.
- slot_free = !out_valid | out_ready.
- in_ready = reset & slot_free & (state != FLUSH); combinational.
- States:
  - IDLE: no run held. Accept b: cur_sym=b, cur_cnt=1; to FLUSH if data_last else RUN.
  - RUN: run held. Accept b with b==cur_sym and cur_cnt<255: cur_cnt+1. Accept b with b!=cur_sym, or cur_cnt==255: load output register with (cur_sym, cur_cnt), out_valid=1; cur_sym=b, cur_cnt=1; split=1 only in the cur_cnt==255, b==cur_sym case. Either case: to FLUSH if data_last else RUN. No accept: hold.
  - FLUSH: final run held, input blocked. When slot_free: load output register with (cur_sym, cur_cnt), out_valid=1, to IDLE.
- Output register: if loaded in a cycle, takes the new pair; else if transfer occurs, out_valid=0; else holds all outputs stable.
- cur_cnt never wraps; 255 + same symbol always splits. Runs of 256 emit (s,255),(s,1).
- A lone byte with data_last in IDLE emits (b,1) via FLUSH.
- data_in and data_last ignored when not accepted.
- Reset (any time, including mid-run or with out_valid high): pending run and output pair discarded; no partial emission.

## Timing
- Reset values: out_valid=0, out_symbol=0x00, out_run=0x00, split=0, in_ready=0 while reset low; state=IDLE, cur_sym=0, cur_cnt=0.
- First cycle after reset release: in_ready=1.
- Terminating byte accepted at edge N -> pair on outputs with out_valid=1 after edge N.
- Last byte accepted at edge N -> FLUSH after N; final pair loaded at first edge ≥N+1 with slot_free, i.e. N+1 if output empty or taken that cycle.
- Throughput: one byte per cycle while out_ready=1; only stall is the single FLUSH cycle per stream.
- split asserted for exactly the one cycle following the edge that performed the cut.
- Simultaneous transfer and load in one cycle: new pair replaces old, out_valid stays 1.

## Test plan
- Reset then stream 0x41,0x41,0x41,0x42(last), out_ready=1 -> pairs (0x41,3) then (0x42,1); in_ready low exactly one cycle (FLUSH); then IDLE.
- 256 × 0xAA then 0xAA(last) -> (0xAA,255) with split pulse, then (0xAA,2); out_run never 0.
- Single byte 0x07 with data_last in IDLE -> exactly one pair (0x07,1) one cycle after FLUSH entry.
- Alternating 0x00,0xFF,... 8 bytes, out_ready held 0 after first pair -> in_ready drops, out_symbol/out_run stable while stalled; on release all 8 pairs (x,1) delivered in order, none lost or duplicated.
- Reset asserted mid-run (cur_cnt=5) and while out_valid=1 -> outputs to reset values immediately, no pair emitted after release; new stream 0x10(last) yields only (0x10,1).
- Random streams (random valid/ready, runs 1–600) vs reference model -> identical pair sequence; sum of out_run equals bytes accepted.
